// File: rtl/uart_rx.sv
// 8N1-style serial receiver: two-flop synchronizer, mid-bit sampling FSM,
// parallel word output with one-cycle good/framing-error strobes.
module uart_rx #(
  parameter int BAUD_DIV       = 2,
  parameter int BAUD_DIV_WIDTH = 8,
  parameter int W              = 8
) (
  input  logic         c,
  input  logic         rst_n,
  input  logic         in,
  output logic [W-1:0] out,
  output logic         out_en,
  output logic         framing_err,
  output logic         busy
);

  localparam int HALF  = BAUD_DIV / 2;
  localparam int BIT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [BAUD_DIV_WIDTH-1:0] HALF_M1  = BAUD_DIV_WIDTH'(HALF - 1);
  localparam logic [BAUD_DIV_WIDTH-1:0] FULL_M1  = BAUD_DIV_WIDTH'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]          LAST_BIT = BIT_W'(W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                    state_reg;
  logic [1:0]                sync_reg;
  logic                      in_s;
  logic [BAUD_DIV_WIDTH-1:0] cnt_reg;
  logic [BIT_W-1:0]          bit_cnt_reg;
  logic [W-1:0]              shift_reg;
  logic [W-1:0]              shift_next;

  // The pin is asynchronous to c; only the second flop is ever looked at.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], in};
    end
  end

  assign in_s = sync_reg[1];

  // LSB arrives first: new bit enters at the MSB and everything moves right.
  assign shift_next[W-1] = in_s;
  generate
    for (genvar gi = 0; gi < W - 1; gi++) begin : g_shift
      assign shift_next[gi] = shift_reg[gi+1];
    end
  endgenerate

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      out         <= '0;
      out_en      <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      out_en      <= 1'b0;
      framing_err <= 1'b0;
      cnt_reg     <= cnt_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!in_s) begin
            state_reg <= START;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (cnt_reg == HALF_M1) begin
            cnt_reg <= '0;
            if (in_s) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
        end
        DATA: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg   <= '0;
            shift_reg <= shift_next;
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        STOP: begin
          // Leaving at mid stop bit gives half a bit of slack for the next start edge.
          if (cnt_reg == FULL_M1) begin
            cnt_reg <= '0;
            if (in_s) begin
              out       <= shift_reg;
              out_en    <= 1'b1;
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              framing_err <= 1'b1;
              state_reg   <= BREAK;
            end
          end
        end
        BREAK: begin
          cnt_reg <= '0;
          if (in_s) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BAUD_DIV=16, W=8: table of frames plus hand-written
// back-to-back, glitch and mid-frame reset sequences, scoreboard on strobes.
module tb_uart_rx;

  localparam int BD   = 16;
  localparam int HALF = BD / 2;
  localparam int LAT  = 2 + HALF + 9 * BD + 1;

  logic       c = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_line = 1'b1;
  logic [7:0] out;
  logic       out_en;
  logic       framing_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_err;
    logic [7:0] exp_out;
  } vec_t;
  vec_t vecs[3];

  uart_rx #(.BAUD_DIV(BD), .BAUD_DIV_WIDTH(8), .W(8)) dut (
    .c(c),
    .rst_n(rst_n),
    .in(in_line),
    .out(out),
    .out_en(out_en),
    .framing_err(framing_err),
    .busy(busy)
  );

  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge c);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_line = b;
    tick(BD);
  endtask

  // Called at posedge+1; returns at posedge+1 so frames chain with no gap.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic [7:0] exp_out);
    sb_t e;
    e.err  = ~stop;
    e.data = exp_out;
    e.cyc  = cyc + LAT;
    sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    check("scoreboard_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge c);
      if (out_en === 1'b1 || framing_err === 1'b1) begin
        check("strobe_exclusive", 32'(out_en & framing_err), 0);
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'({out_en, framing_err}), 0);
        end else begin
          e = sb.pop_front();
          $display("rx strobe: out=%02h framing_err=%b cycle=%0d", out, framing_err, cyc);
          check("strobe_kind", 32'(framing_err), 32'(e.err));
          check("strobe_out", 32'(out), 32'(e.data));
          check("strobe_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  initial begin
    logic seen_busy;
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_err: 1'b0, exp_out: 8'hA5};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_err: 1'b1, exp_out: 8'hA5};
    vecs[2] = '{data: 8'h81, stop: 1'b1, exp_err: 1'b0, exp_out: 8'h81};

    fork
      monitor();
    join_none

    // Reset held with the line toggling
    tick(1);
    for (int i = 0; i < 20; i++) begin
      in_line = 1'($urandom_range(0, 1));
      tick(1);
      check("reset_outputs", 32'({out, out_en, framing_err, busy}), 0);
    end
    in_line = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(40);
    check("idle_after_reset", 32'({out, busy}), 0);

    // Table-driven frames
    for (int v = 0; v < 3; v++) begin
      $display("frame: data=%02h stop=%b", vecs[v].data, vecs[v].stop);
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].exp_out);
      if (!vecs[v].stop) begin
        tick(20);
        check("busy_in_break", 32'(busy), 1);
        tick(20);
        in_line = 1'b1;
        tick(5);
      end
      wait_drain();
      tick(4);
      check("frame_out", 32'(out), 32'(vecs[v].exp_out));
      check("frame_idle", 32'(busy), 0);
    end

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 8'h00);
    send_frame(8'hFF, 1'b1, 8'hFF);
    send_frame(8'h5A, 1'b1, 8'h5A);
    wait_drain();
    tick(4);
    check("b2b_out", 32'(out), 32'h5A);

    // Short low glitch
    $display("glitch: 5 cycles low");
    seen_busy = 1'b0;
    in_line = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      seen_busy = seen_busy | busy;
    end
    in_line = 1'b1;
    tick(12);
    check("glitch_busy_seen", 32'(seen_busy), 1);
    check("glitch_busy_low", 32'(busy), 0);
    check("glitch_out_kept", 32'(out), 32'h5A);

    // Reset in the middle of data bit 3 of 0xC3
    $display("frame: data=c3 aborted by reset");
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(i < 2);
    in_line = 1'b0;
    tick(8);
    check("midframe_busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check("midframe_reset", 32'({out, out_en, framing_err, busy}), 0);
    @(posedge c);
    #1;
    tick(2);
    in_line = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("post_reset_idle", 32'(busy), 0);
    send_frame(8'h96, 1'b1, 8'h96);
    wait_drain();
    tick(4);
    check("post_reset_out", 32'(out), 32'h96);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side counterpart of the team's `uart_tx`. It recovers 8N1-style frames from the `in` line: idle high, one start bit (0), W data bits LSB first, one stop bit (1), each bit BAUD_DIV clocks long. It presents each good word on a parallel output with a one-cycle strobe. It sits between the board UART pin and the motor controller's command parser, and must interoperate with `uart_tx` configured with identical parameters.

## Interface
- BAUD_DIV, 2: clock cycles per bit; must be >= 2. HALF = BAUD_DIV/2, integer division.
- BAUD_DIV_WIDTH, 8: width of the bit-period counter; must hold BAUD_DIV-1.
- W, 8: data bits per frame.
- c  input  1  clock; single clock domain.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in  input  1  serial line; asynchronous to c; idles high.
- out  output  W  last correctly framed word; held until the next good frame.
- out_en  output  1  one-cycle strobe; `out` is new this cycle.
- framing_err  output  1  one-cycle strobe; stop bit sampled as 0.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- The two-flop synchronizer on `in` produces `in_s`. Both flops reset to 1. All decisions use `in_s` only.
- The bit-period counter is BAUD_DIV_WIDTH wide. It is cleared on every state entry and on every sample point, and it never wraps.
- The shift register is W bits. Each data sample shifts into the MSB and shifts right, so bit 0 arrives first and ends in `out[0]`.
- The bit counter runs from 0 to W-1.
- States:
  - IDLE: wait for `in_s`==0. Clear the counter and go to START.
  - START: at counter==HALF-1, sample the line. If it is 0, go to DATA. If it is 1, the frame is a glitch: go to IDLE with no strobe.
  - DATA: at counter==BAUD_DIV-1, sample one bit. After the W-th bit, go to STOP.
  - STOP: at counter==BAUD_DIV-1, sample the line.
    - If it is 1, load `out` from the shift register, pulse `out_en`, and go to IDLE.
    - If it is 0, pulse `framing_err`, leave `out` unchanged, and go to BREAK.
  - BREAK: wait for `in_s`==1, then go to IDLE. This covers line breaks and held-low lines.
  - Undefined encodings go to IDLE.
- The return to IDLE happens at mid stop bit. This leaves half a bit of margin to catch the next start edge, so back-to-back frames are supported.
- There is no flow control. A new good frame overwrites `out` regardless of whether the consumer read the previous word. The consumer must take `out` on `out_en`.
- `out_en` and `framing_err` are never high in the same cycle.

## Timing
- Reset values: `out`=0, `out_en`=0, `framing_err`=0, `busy`=0. The state is IDLE, all counters are 0, and the synchronizer holds 1.
- Asserting `rst_n` mid-frame aborts the frame immediately. No strobe is produced.
- After `rst_n` deasserts, reception restarts with IDLE-state edge detection.
- Let E be the first cycle in which IDLE observes `in_s`==0. E is 2 clock edges after `in` falls at the pin.
- `busy` is high from E+1 until the cycle after the state returns to IDLE.
- Sample points:
  - Start-bit sample: E+HALF.
  - Data bit k (k=0..W-1) sample: E+HALF+(k+1)·BAUD_DIV.
  - Stop-bit sample: E+HALF+(W+1)·BAUD_DIV.
- `out_en` or `framing_err` is high for exactly one cycle, at stop sample + 1. `out` is valid in that same cycle.
- Latency, pin fall to `out_en`: 2 + HALF + (W+1)·BAUD_DIV + 1 cycles. For BAUD_DIV=16, W=8 this is 155.
- Glitch rejection: a low pulse on `in_s` shorter than HALF cycles produces no strobe. `busy` falls within HALF+1 cycles.

## Test plan
- Reset: hold `rst_n`=0 with `in` toggling.
  - Required: `out`=0, `out_en`=0, `framing_err`=0, `busy`=0 throughout.
  - After release with `in`=1, no activity.
- Loopback with `uart_tx` (BAUD_DIV=16, W=8) sending 0xA5.
  - Required: exactly one `out_en`, with `out`=0xA5, 155 cycles after `in` falls.
  - `framing_err` is never asserted.
- Back-to-back `uart_tx` frames 0x00, 0xFF, 0x5A with no idle gap.
  - Required: three `out_en` pulses, with `out`=0x00, 0xFF, 0x5A in order, each 160 cycles apart.
- Glitch: drive `in` low for 5 cycles at BAUD_DIV=16, then hold high.
  - Required: no strobe; `busy` returns to 0; `out` is unchanged.
- Framing error: send start bit, data 0x3C, stop bit 0, then hold `in` low for 40 cycles, then high.
  - Required: one `framing_err` pulse; no `out_en`; `out` keeps its prior value; `busy` stays high until `in_s` returns to 1.
  - A following good frame 0x81 is then received correctly.
- Reset mid-frame: assert `rst_n` during data bit 3 of a 0xC3 frame.
  - Required: outputs return to reset values at once.
  - A full 0x96 frame sent after release yields `out`=0x96 with `out_en`.
